nemo_seq: RTL and testbench

//  SPI transaction sequencer for the iNEMO gyro inside the inertial interface.

---
 rtl/nemo_seq_if.sv | 14 +
 rtl/nemo_seq.sv | 163 ++++++++++++++++
 tb/tb_nemo_seq.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nemo_seq_if.sv
// SPI monarch handshake plus yaw-rate result bus for the iNEMO sequencer.
// master: sequencer side (drives wrt/cmd/vld/yaw_rt, observes done/rspns).
// slave : monarch/integrator side (the reverse).
interface nemo_seq_if;
    logic        wrt;     // start transaction, 1-clk pulse
    logic [15:0] cmd;     // command word, held from wrt until done
    logic        done;    // transaction complete, 1-clk pulse
    logic [15:0] rspns;   // read response, data in [7:0]
    logic        vld;     // 1-clk pulse: yaw_rt updated
    logic [15:0] yaw_rt;  // signed yaw rate {yawH,yawL}

    modport master (output wrt, cmd, vld, yaw_rt, input done, rspns);
    modport slave  (input wrt, cmd, vld, yaw_rt, output done, rspns);
endinterface

// File: rtl/nemo_seq.sv
// Purpose     : iNEMO gyro SPI sequencer: power-up wait, 3 init writes, then a yawL/yawH read pair per INT edge.
// Latency     : INT edge -> wrt(RDL) 3 clks from IDLE; last done -> vld 1 clk.
// Backpressure: each transaction waits for done; with NEMO_TMO_EN a done watchdog sets err and abandons it.
//
// Ports: clk, rst_n (async active-low), INT (async data-ready), spi (nemo_seq_if.master:
//        wrt/cmd/done/rspns/vld/yaw_rt), init_done (sticky), err (sticky timeout, 0 without NEMO_TMO_EN).
// Optional feature macro: NEMO_TMO_EN (done watchdog of width TMO_W).
module nemo_seq #(
    parameter int FAST_SIM = 1,   // 1: power-up wait 2^10 clks, 0: 2^16 clks
    parameter int TMO_W    = 12   // done-watchdog width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          INT,
    nemo_seq_if.master    spi,
    output logic          init_done,
    output logic          err
);
    localparam int PW = (FAST_SIM != 0) ? 10 : 16;

    typedef enum logic [2:0] {PWRUP, INIT1, INIT2, INIT3, IDLE, RDL, RDH, VLD} state_t;

    state_t         state;
    logic [PW-1:0]  pwr_cnt;
    logic [7:0]     yaw_l;
    logic           int_s1, int_s2, int_d;
    logic           pend;
    logic           int_edge;
    logic           take;
    logic [TMO_W-1:0] tmo_cnt;
    logic           tmo_hit;

    assign int_edge = int_s2 & ~int_d;
    // done coinciding with wrt cannot belong to the transaction just launched
    assign take     = spi.done & ~spi.wrt;
    assign tmo_hit  = (&tmo_cnt) & ~spi.wrt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
            int_d  <= 1'b0;
        end else begin
            int_s1 <= INT;
            int_s2 <= int_s1;
            int_d  <= int_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PWRUP;
            pwr_cnt    <= '0;
            yaw_l      <= 8'h00;
            pend       <= 1'b0;
            init_done  <= 1'b0;
            spi.wrt    <= 1'b0;
            spi.cmd    <= 16'h0000;
            spi.vld    <= 1'b0;
            spi.yaw_rt <= 16'h0000;
        end else begin
            spi.wrt <= 1'b0;
            spi.vld <= 1'b0;

            // IDLE consumes the raw edge too, so the 3-clk INT->wrt latency holds
            if (state == IDLE && (pend || int_edge))
                pend <= 1'b0;
            else if (int_edge && init_done)
                pend <= 1'b1;

            case (state)
                PWRUP: begin
                    // wraps back to zero on exit, so a restart gets the full wait
                    pwr_cnt <= pwr_cnt + PW'(1);
                    if (&pwr_cnt) begin
                        state   <= INIT1;
                        spi.wrt <= 1'b1;
                        spi.cmd <= 16'h0D02;
                    end
                end
                INIT1: begin
                    if (take) begin
                        state   <= INIT2;
                        spi.wrt <= 1'b1;
                        spi.cmd <= 16'h1160;
                    end else if (tmo_hit) begin
                        state <= PWRUP;
                    end
                end
                INIT2: begin
                    if (take) begin
                        state   <= INIT3;
                        spi.wrt <= 1'b1;
                        spi.cmd <= 16'h1440;
                    end else if (tmo_hit) begin
                        state <= PWRUP;
                    end
                end
                INIT3: begin
                    if (take) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end else if (tmo_hit) begin
                        state <= PWRUP;
                    end
                end
                IDLE: begin
                    if (pend || int_edge) begin
                        state   <= RDL;
                        spi.wrt <= 1'b1;
                        spi.cmd <= 16'hA600;
                    end
                end
                RDL: begin
                    if (take) begin
                        yaw_l   <= spi.rspns[7:0];
                        state   <= RDH;
                        spi.wrt <= 1'b1;
                        spi.cmd <= 16'hA700;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                RDH: begin
                    // result registered here so vld/yaw_rt appear during VLD
                    if (take) begin
                        spi.yaw_rt <= {spi.rspns[7:0], yaw_l};
                        spi.vld    <= 1'b1;
                        state      <= VLD;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                VLD:     state <= IDLE;
                default: state <= PWRUP;
            endcase
        end
    end

`ifdef NEMO_TMO_EN
    logic waiting;
    assign waiting = (state == INIT1) || (state == INIT2) || (state == INIT3) ||
                     (state == RDL)   || (state == RDH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (!waiting || spi.wrt || spi.done)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit && waiting)
                err <= 1'b1;
        end
    end
`else
    assign tmo_cnt = '0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_nemo_seq.sv
`timescale 1ns/1ps
module tb_nemo_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic INT;
    logic init_done, err;

    nemo_seq_if sif();

    nemo_seq #(.FAST_SIM(1), .TMO_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .spi(sif),
        .init_done(init_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor records
    int          nc = 0;
    logic [15:0] cmd_log[$];
    logic [15:0] vld_log[$];
    logic [15:0] exp_q[$];
    int          done_nc = 0, vld_nc = 0, init_nc = 0;
    int          wrt_cnt = 0, yaw_bad = 0;

    // responder controls
    bit          withhold = 1'b0, inject_done = 1'b0, fix_en = 1'b0;
    int          dly_lo = 0, dly_hi = 3;
    logic [7:0]  fix_l = 8'h00, fix_h = 8'h00, last_l = 8'h00;

    logic [15:0] init_cmds [3];
    initial begin
        init_cmds[0] = 16'h0D02;
        init_cmds[1] = 16'h1160;
        init_cmds[2] = 16'h1440;
    end

    // Behavioural SPI monarch: answers every wrt after a random delay and
    // records the yaw value each completed read pair should produce.
    initial begin : responder
        bit          busy;
        int          dly;
        logic [15:0] cur;
        logic [7:0]  h;
        busy = 1'b0; dly = 0; cur = '0; h = '0;
        sif.done = 1'b0; sif.rspns = '0;
        forever begin
            @(negedge clk);
            sif.done = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (inject_done && !busy) begin
                sif.done = 1'b1;
                sif.rspns = 16'($urandom);
                inject_done = 1'b0;
            end else if (busy) begin
                if (dly == 0) begin
                    busy = 1'b0;
                    sif.done = 1'b1;
                    if (cur == 16'hA600) begin
                        last_l = fix_en ? fix_l : 8'($urandom);
                        sif.rspns = {8'($urandom), last_l};
                    end else if (cur == 16'hA700) begin
                        h = fix_en ? fix_h : 8'($urandom);
                        sif.rspns = {8'($urandom), h};
                        exp_q.push_back({h, last_l});
                    end else begin
                        sif.rspns = 16'($urandom);
                    end
                end else begin
                    dly--;
                end
            end
            if (rst_n && sif.wrt && !withhold) begin
                busy = 1'b1;
                cur  = sif.cmd;
                dly  = $urandom_range(dly_hi, dly_lo);
            end
        end
    end

    initial begin : monitor
        bit          prev_init;
        logic [15:0] prev_yaw;
        prev_init = 1'b0; prev_yaw = '0;
        forever begin
            @(negedge clk);
            #1;
            nc++;
            if (sif.wrt) begin cmd_log.push_back(sif.cmd); wrt_cnt++; end
            if (sif.done) done_nc = nc;
            if (sif.vld) begin
                vld_log.push_back(sif.yaw_rt);
                vld_nc = nc;
            end else if (rst_n && sif.yaw_rt !== prev_yaw) begin
                yaw_bad++;
            end
            if (init_done && !prev_init) init_nc = nc;
            prev_init = init_done;
            prev_yaw  = sif.yaw_rt;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_int(input int len);
        INT = 1'b1;
        repeat (len) tick();
        INT = 1'b0;
    endtask

    task automatic wait_vld(input int target, input int budget, output bit ok);
        int c;
        c = 0;
        while (vld_log.size() < target && c < budget) begin tick(); c++; end
        ok = (vld_log.size() >= target);
    endtask

    task automatic wait_init(input int budget, output bit ok);
        int c;
        c = 0;
        while (!init_done && c < budget) begin tick(); c++; end
        ok = init_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; INT = 1'b0;
        repeat (3) tick();
        n_checks++; if (sif.wrt !== 1'b0) begin n_fail++; $display("FAIL reset_wrt got %b want 0", sif.wrt); end
        n_checks++; if (sif.cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd got %h want 0000", sif.cmd); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b want 0", init_done); end
        n_checks++; if (sif.vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", sif.vld); end
        n_checks++; if (sif.yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL reset_yaw got %h want 0000", sif.yaw_rt); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    // power-up wait, init writes; INT and stray done during power-up are ignored
    task automatic test_init(input string tag);
        int  c;
        bit  ok;
        cmd_log.delete();
        wrt_cnt = 0;
        c = 0;
        rst_n = 1'b1;
        while (c < 2000) begin
            tick(); c++;
            if (c == 100) INT = 1'b1;
            if (c == 103) INT = 1'b0;
            if (c == 200) inject_done = 1'b1;
            if (sif.wrt) break;
        end
        n_checks++; if (c !== 1024) begin n_fail++; $display("FAIL %s_pwrup_len got %0d want 1024", tag, c); end
        n_checks++; if (wrt_cnt !== 1) begin n_fail++; $display("FAIL %s_early_wrt got %0d wrt want 1", tag, wrt_cnt); end
        wait_init(300, ok);
        n_checks++; if (!ok || init_nc !== done_nc + 1) begin
            n_fail++; $display("FAIL %s_init_done_lat got %0d want %0d", tag, init_nc, done_nc + 1);
        end
        repeat (20) tick();
        n_checks++; if (cmd_log.size() !== 3) begin n_fail++; $display("FAIL %s_init_count got %0d want 3", tag, cmd_log.size()); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (cmd_log[k] !== init_cmds[k]) begin
                n_fail++; $display("FAIL %s_init_cmd%0d got %h want %h", tag, k, cmd_log[k], init_cmds[k]);
            end
        end
    endtask

    task automatic test_idle_done();
        int w0, v0;
        w0 = wrt_cnt; v0 = vld_log.size();
        inject_done = 1'b1;
        repeat (10) tick();
        n_checks++; if (wrt_cnt !== w0) begin n_fail++; $display("FAIL idle_done_wrt got %0d want %0d", wrt_cnt, w0); end
        n_checks++; if (vld_log.size() !== v0) begin n_fail++; $display("FAIL idle_done_vld got %0d want %0d", vld_log.size(), v0); end
        n_checks++; if (vld_log.size() !== 0) begin n_fail++; $display("FAIL pre_init_int_vld got %0d want 0", vld_log.size()); end
    endtask

    task automatic test_read();
        int c, bad;
        bit ok;
        vld_log.delete(); exp_q.delete(); cmd_log.delete();
        fix_en = 1'b1; fix_l = 8'h34; fix_h = 8'h12;
        INT = 1'b1;
        c = 0;
        while (c < 20) begin tick(); c++; if (sif.wrt) break; end
        INT = 1'b0;
        n_checks++; if (c !== 3) begin n_fail++; $display("FAIL int_to_wrt_lat got %0d want 3", c); end
        n_checks++; if (sif.cmd !== 16'hA600) begin n_fail++; $display("FAIL rdl_cmd got %h want a600", sif.cmd); end
        wait_vld(1, 100, ok);
        n_checks++; if (!ok || vld_nc !== done_nc + 1) begin n_fail++; $display("FAIL done_to_vld_lat got %0d want %0d", vld_nc, done_nc + 1); end
        repeat (5) tick();
        n_checks++; if (vld_log.size() !== 1) begin n_fail++; $display("FAIL fixed_vld_count got %0d want 1", vld_log.size()); end
        n_checks++; if (vld_log[0] !== 16'h1234) begin n_fail++; $display("FAIL fixed_yaw got %h want 1234", vld_log[0]); end
        n_checks++; if (sif.yaw_rt !== 16'h1234) begin n_fail++; $display("FAIL yaw_hold got %h want 1234", sif.yaw_rt); end
        fix_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            dly_lo = 0; dly_hi = $urandom_range(0, 6);
            pulse_int($urandom_range(1, 4));
            wait_vld(i + 1, 200, ok);
            repeat ($urandom_range(3, 8)) tick();
            n_checks++; if (!ok || vld_log.size() !== i + 1 || vld_log[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_yaw%0d got %h want %h (count %0d)", i, vld_log[i], exp_q[i], vld_log.size());
            end
        end
        bad = 0;
        for (int k = 0; k < cmd_log.size(); k++)
            if (cmd_log[k] !== ((k % 2) ? 16'hA700 : 16'hA600)) bad++;
        n_checks++; if (cmd_log.size() !== 18 || bad !== 0) begin
            n_fail++; $display("FAIL read_cmds got %0d cmds %0d wrong want 18 0", cmd_log.size(), bad);
        end
        n_checks++; if (yaw_bad !== 0) begin n_fail++; $display("FAIL yaw_change_without_vld got %0d want 0", yaw_bad); end
`ifndef NEMO_TMO_EN
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied got %b want 0", err); end
`endif
        dly_lo = 0; dly_hi = 3;
    endtask

    // two edges during RDH collapse into exactly one extra read pair
    task automatic test_back_to_back();
        int  c, bad;
        bit  ok;
        vld_log.delete(); exp_q.delete(); cmd_log.delete();
        dly_lo = 10; dly_hi = 12;
        pulse_int(1);
        c = 0;
        while (cmd_log.size() < 2 && c < 100) begin tick(); c++; end
        pulse_int(1); tick(); tick(); pulse_int(1);
        wait_vld(2, 300, ok);
        repeat (60) tick();
        n_checks++; if (vld_log.size() !== 2) begin n_fail++; $display("FAIL b2b_vld_count got %0d want 2", vld_log.size()); end
        bad = 0;
        for (int k = 0; k < 4; k++)
            if (cmd_log[k] !== ((k % 2) ? 16'hA700 : 16'hA600)) bad++;
        n_checks++; if (cmd_log.size() !== 4 || bad !== 0) begin
            n_fail++; $display("FAIL b2b_cmds got %0d cmds %0d wrong want 4 0", cmd_log.size(), bad);
        end
        n_checks++; if (vld_log[0] !== exp_q[0] || vld_log[1] !== exp_q[1]) begin
            n_fail++; $display("FAIL b2b_yaw got %h %h want %h %h", vld_log[0], vld_log[1], exp_q[0], exp_q[1]);
        end
        dly_lo = 0; dly_hi = 3;
    endtask

    task automatic test_reset_mid();
        int c, v0;
        v0 = vld_log.size();
        dly_lo = 15; dly_hi = 15;
        cmd_log.delete();
        pulse_int(1);
        c = 0;
        while (cmd_log.size() < 2 && c < 100) begin tick(); c++; end
        repeat (3) tick();
        n_checks++; if (sif.cmd !== 16'hA700) begin n_fail++; $display("FAIL mid_in_rdh got cmd %h want a700", sif.cmd); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sif.yaw_rt !== 16'h0000 || init_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_async got yaw %h init %b want 0000 0", sif.yaw_rt, init_done);
        end
        tick();
        n_checks++; if (sif.wrt !== 1'b0) begin n_fail++; $display("FAIL mid_wrt got %b want 0", sif.wrt); end
        n_checks++; if (sif.yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL mid_yaw got %h want 0000", sif.yaw_rt); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_init_done got %b want 0", init_done); end
        repeat (3) tick();
        dly_lo = 0; dly_hi = 3;
        test_init("replay");
        n_checks++; if (vld_log.size() !== v0) begin n_fail++; $display("FAIL mid_aborted_vld got %0d want %0d", vld_log.size(), v0); end
    endtask

`ifdef NEMO_TMO_EN
    task automatic test_timeout();
        int          c, w0, v0;
        bit          ok;
        logic [15:0] y0;
        y0 = sif.yaw_rt; v0 = vld_log.size();
        withhold = 1'b1;
        pulse_int(1);
        repeat (5) tick();
        w0 = wrt_cnt;
        c = 0;
        while (!err && c < 5000) begin tick(); c++; end
        repeat (10) tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", err); end
        n_checks++; if (sif.yaw_rt !== y0) begin n_fail++; $display("FAIL tmo_yaw got %h want %h", sif.yaw_rt, y0); end
        n_checks++; if (wrt_cnt !== w0 || vld_log.size() !== v0) begin
            n_fail++; $display("FAIL tmo_quiet got wrt %0d vld %0d want %0d %0d", wrt_cnt, vld_log.size(), w0, v0);
        end
        withhold = 1'b0;
        exp_q.delete();
        pulse_int(1);
        wait_vld(v0 + 1, 200, ok);
        tick();
        n_checks++; if (!ok || vld_log[v0] !== exp_q[0]) begin
            n_fail++; $display("FAIL tmo_next_read got %h want %h", vld_log[v0], exp_q[0]);
        end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %b want 1", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_init("init");
        test_idle_done();
        test_read();
        test_back_to_back();
        test_reset_mid();
`ifdef NEMO_TMO_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
